// File: rtl/encoder_arb_ctrl.sv
`timescale 1ns/1ps
// encoder_arb_ctrl: round-robin arbiter that feeds one shared nibble encoder
// from two requesters and returns the encoded result with a one-cycle ack.
// An optional 4-digit multiplexed display scan is compiled in when the macro
// ENC_ARB_SCAN_EN is defined; otherwise the display outputs are tied off.
module encoder_arb_ctrl #(
    parameter int unsigned ENC_LAT  = 1,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic [3:0] data0_i,
    input  logic [3:0] data1_i,
    output logic       ack0_o,
    output logic       ack1_o,
    output logic [3:0] result_o,
    output logic       busy_o,
    output logic       enc_ready_o,
    output logic [3:0] enc_entrada_o,
    input  logic [3:0] enc_saida_i,
    input  logic [6:0] disp3_i,
    input  logic [6:0] disp2_i,
    input  logic [6:0] disp1_i,
    input  logic [6:0] disp0_i,
    output logic [6:0] seg_o,
    output logic [3:0] an_o
);

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DIG_N  = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned LAT_W  = 4;
    localparam int unsigned SCAN_W = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic               last_grant_q;   // 1: requester 1 was granted most recently
    logic [LAT_W-1:0]   lat_cnt_q;
    logic [NIB_W-1:0]   enc_entrada_q;
    logic [NIB_W-1:0]   result_q;
    logic               ack0_q;
    logic               ack1_q;
    logic               busy_q;
    logic               enc_ready_q;
    logic               ack0_d;
    logic               ack1_d;
    logic               busy_d;
    logic               enc_ready_d;

    logic               any_req;
    logic               win1;
    logic               grant_edge;
    logic               lat_done;

    assign any_req    = req0_i || req1_i;
    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign win1       = req1_i && (!req0_i || !last_grant_q);
    assign grant_edge = (state_q == S_IDLE) && any_req;
    assign lat_done   = (lat_cnt_q == LAT_W'(ENC_LAT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; arbitration only happens from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (any_req) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT:    if (lat_done) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so registered outputs align with it.
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        enc_ready_d = (state_d == S_ISSUE);
        ack0_d      = (state_d == S_CAPTURE) && !last_grant_q;
        ack1_d      = (state_d == S_CAPTURE) &&  last_grant_q;
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= 1'b0;
            enc_ready_q <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            enc_ready_q <= enc_ready_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
        end
    end

    // Grant bookkeeping, encoder latency counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q  <= 1'b1;
            enc_entrada_q <= '0;
            lat_cnt_q     <= '0;
            result_q      <= '0;
        end else begin
            if (grant_edge) begin
                last_grant_q  <= win1;
                enc_entrada_q <= win1 ? data1_i : data0_i;
            end
            lat_cnt_q <= (state_q == S_WAIT) ? lat_cnt_q + LAT_W'(1) : '0;
            if ((state_q == S_WAIT) && lat_done) begin
                result_q <= enc_saida_i;
            end
        end
    end

    assign ack0_o        = ack0_q;
    assign ack1_o        = ack1_q;
    assign busy_o        = busy_q;
    assign enc_ready_o   = enc_ready_q;
    assign enc_entrada_o = enc_entrada_q;
    assign result_o      = result_q;

`ifdef ENC_ARB_SCAN_EN
    logic [SCAN_W-1:0] scan_cnt_q;
    logic [IDX_W-1:0]  digit_q;
    logic [SEG_W-1:0]  seg_q;
    logic [SEG_W-1:0]  seg_sel;
    logic [DIG_N-1:0]  an_q;
    logic              scan_wrap;

    assign scan_wrap = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));

    // Scan divider and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            digit_q    <= '0;
        end else begin
            scan_cnt_q <= scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
            if (scan_wrap) begin
                digit_q <= digit_q + IDX_W'(1);
            end
        end
    end

    // Segment pattern for the current digit.
    always_comb begin
        seg_sel = disp0_i;
        case (digit_q)
            2'd0:    seg_sel = disp0_i;
            2'd1:    seg_sel = disp1_i;
            2'd2:    seg_sel = disp2_i;
            2'd3:    seg_sel = disp3_i;
            default: seg_sel = disp0_i;
        endcase
    end

    // Registered digit enable (active-low one-hot) and segments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= 4'b1110;
            seg_q <= 7'b1111111;
        end else begin
            an_q  <= ~(DIG_N'(1) << digit_q);
            seg_q <= seg_sel;
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;
`else
    logic unused_disp;
    assign unused_disp = ^{disp3_i, disp2_i, disp1_i, disp0_i};
    assign an_o  = 4'b1111;
    assign seg_o = 7'b1111111;
`endif

endmodule

// File: tb/tb_encoder_arb_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for encoder_arb_ctrl: table of single transactions,
// scoreboard of expected acks/results, plus hand-written corner sequences.
module tb_encoder_arb_ctrl;

    localparam int unsigned ENC_LAT  = 1;
    localparam int unsigned SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] data0 = '0, data1 = '0;
    logic       ack0, ack1, busy, enc_ready;
    logic [3:0] result, enc_entrada, enc_saida, an;
    logic [6:0] seg;
    logic [6:0] disp_tab [4];

    initial begin
        disp_tab[0] = 7'h01;
        disp_tab[1] = 7'h02;
        disp_tab[2] = 7'h04;
        disp_tab[3] = 7'h08;
    end

    // Encoder model: fixed XOR mapping, combinational.
    assign enc_saida = enc_entrada ^ 4'hA;

    encoder_arb_ctrl #(.ENC_LAT(ENC_LAT), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_i(req0), .req1_i(req1), .data0_i(data0), .data1_i(data1),
        .ack0_o(ack0), .ack1_o(ack1), .result_o(result), .busy_o(busy),
        .enc_ready_o(enc_ready), .enc_entrada_o(enc_entrada), .enc_saida_i(enc_saida),
        .disp3_i(disp_tab[3]), .disp2_i(disp_tab[2]), .disp1_i(disp_tab[1]), .disp0_i(disp_tab[0]),
        .seg_o(seg), .an_o(an)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       g;
        logic [3:0] data;
        logic [3:0] res;
    } exp_t;

    typedef struct {
        logic       r0;
        logic       r1;
        logic [3:0] d0;
        logic [3:0] d1;
        logic       g;
        logic [3:0] data;
        logic [3:0] res;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Watch the DUT until every queued transaction has been acked.
    task automatic drain(input int budget, input int gap, input bit scramble);
        int   rdy_cyc = -1;
        int   last_ack = -1;
        exp_t e;
        for (int n = 0; n < budget && sb.size() > 0; n++) begin
            @(negedge clk);
            if (enc_ready) begin
                rdy_cyc = cyc;
                check("enc_entrada", 32'(enc_entrada), 32'(sb[0].data));
                if (scramble) begin
                    data0 = ~data0;
                    data1 = ~data1;
                end
            end
            if (ack0 || ack1) begin
                e = sb.pop_front();
                check("ack_sel", 32'({ack1, ack0}), e.g ? 32'd2 : 32'd1);
                check("result", 32'(result), 32'(e.res));
                check("entrada_hold", 32'(enc_entrada), 32'(e.data));
                check("latency", 32'(cyc - rdy_cyc), 32'(ENC_LAT + 1));
                if (gap > 0 && last_ack >= 0) check("ack_gap", 32'(cyc - last_ack), 32'(gap));
                last_ack = cyc;
            end
        end
        if (sb.size() > 0) begin
            check("ack_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        @(negedge clk);
        req0  = v.r0;
        req1  = v.r1;
        data0 = v.d0;
        data1 = v.d1;
        e.g    = v.g;
        e.data = v.data;
        e.res  = v.res;
        sb.push_back(e);
        drain(12, 0, 1'b1);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack0"}, 32'(ack0), 32'd0);
        check({tag, "_ack1"}, 32'(ack1), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_enc_ready"}, 32'(enc_ready), 32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_enc_entrada"}, 32'(enc_entrada), 32'd0);
`ifdef ENC_ARB_SCAN_EN
        check({tag, "_an"}, 32'(an), 32'hE);
`else
        check({tag, "_an"}, 32'(an), 32'hF);
`endif
        check({tag, "_seg"}, 32'(seg), 32'h7F);
    endtask

    initial begin
        int         dig;
        logic [3:0] an_exp;
        logic [6:0] seg_exp;
        exp_t       e;

        // {r0, r1, d0, d1, winner, winner data, expected result}
        vecs[0] = '{1'b1, 1'b0, 4'h5, 4'h0, 1'b0, 4'h5, 4'hF};
        vecs[1] = '{1'b0, 1'b1, 4'h0, 4'h3, 1'b1, 4'h3, 4'h9};
        vecs[2] = '{1'b1, 1'b1, 4'h7, 4'hC, 1'b0, 4'h7, 4'hD};
        vecs[3] = '{1'b1, 1'b1, 4'h1, 4'hE, 1'b1, 4'hE, 4'h4};
        vecs[4] = '{1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 4'h0, 4'hA};
        vecs[5] = '{1'b0, 1'b1, 4'h0, 4'h8, 1'b1, 4'h8, 4'h2};

        // Reset state.
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Display scan from reset release, edge by edge.
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
`ifdef ENC_ARB_SCAN_EN
            dig     = ((n - 1) / int'(SCAN_DIV)) % 4;
            an_exp  = ~(4'b0001 << dig);
            seg_exp = disp_tab[dig];
`else
            an_exp  = 4'b1111;
            seg_exp = 7'h7F;
`endif
            check("scan_an", 32'(an), 32'(an_exp));
            check("scan_seg", 32'(seg), 32'(seg_exp));
            check("idle_busy", 32'(busy), 32'd0);
        end

        // Table of single transactions.
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Late request from requester 1 during requester 0's WAIT.
        @(negedge clk);
        req0 = 1'b1;
        data0 = 4'h1;
        @(negedge clk);
        check("late_issue_ready", 32'(enc_ready), 32'd1);
        check("late_issue_entrada", 32'(enc_entrada), 32'h1);
        @(negedge clk);
        req1 = 1'b1;
        data1 = 4'h9;
        check("late_wait_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("late_ack0", 32'(ack0), 32'd1);
        check("late_ack1", 32'(ack1), 32'd0);
        check("late_result0", 32'(result), 32'hB);
        check("late_entrada_kept", 32'(enc_entrada), 32'h1);
        req0 = 1'b0;
        e.g = 1'b1;
        e.data = 4'h9;
        e.res = 4'h3;
        sb.push_back(e);
        drain(12, 0, 1'b1);
        req1 = 1'b0;

        // Reset asserted during WAIT aborts the transaction.
        @(negedge clk);
        req0 = 1'b1;
        data0 = 4'hB;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        req0 = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("abort_no_ack", 32'({ack1, ack0}), 32'd0);
        end
        rst_n = 1'b1;
        run_vec('{1'b1, 1'b1, 4'h2, 4'h5, 1'b0, 4'h2, 4'h8});
        run_vec('{1'b1, 1'b0, 4'h6, 4'h0, 1'b0, 4'h6, 4'hC});

        // Both requests held from reset: alternating grants, back to back.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        data0 = 4'h2;
        data1 = 4'h6;
        for (int k = 0; k < 4; k++) begin
            e.g    = k[0];
            e.data = k[0] ? 4'h6 : 4'h2;
            e.res  = k[0] ? 4'hC : 4'h8;
            sb.push_back(e);
        end
        req0 = 1'b1;
        req1 = 1'b1;
        drain(30, int'(ENC_LAT) + 3, 1'b0);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        check("final_idle_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
